// File: rtl/fpga_cmd_master_if.sv
// SPI bus bundle between the command master and the FPGA slave.
// Mode 0, MSB first; the master owns ncs/sck/mosi.
interface fpga_cmd_master_if;
  logic ncs;
  logic sck;
  logic mosi;
  logic miso;

  modport master (
    output ncs,
    output sck,
    output mosi,
    input  miso
  );

  modport slave (
    input  ncs,
    input  sck,
    input  mosi,
    output miso
  );
endinterface

// File: rtl/fpga_cmd_master.sv
// SPI command master: sends a command byte plus payload and
// captures the full-duplex response into a readable buffer.
module fpga_cmd_master #(
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 8,
  parameter int MAX_BYTES  = 15
) (
  input  logic       sysclk,
  input  logic       rst,
  input  logic       start,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_code,
  input  logic [3:0] num_bytes,
  input  logic       tx_we,
  input  logic [3:0] tx_addr,
  input  logic [7:0] tx_data,
  input  logic [3:0] rx_addr,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       status_ok,
  output logic       motors_en,
  fpga_cmd_master_if.master spi
);

  localparam logic [3:0]  MAXB     = 4'(MAX_BYTES);
  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    GAP
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] gap_q, gap_d;
  logic [6:0]  bit_q, bit_d;
  logic [3:0]  nbytes_q, nbytes_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [6:0]  shift_q, shift_d;
  logic        ncs_q, ncs_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        status_ok_q, status_ok_d;
  logic        motors_en_q, motors_en_d;
  logic [7:0]  tx_buf_q [MAX_BYTES];
  logic [7:0]  tx_buf_d [MAX_BYTES];
  logic [7:0]  rx_buf_q [MAX_BYTES];
  logic [7:0]  rx_buf_d [MAX_BYTES];

  logic        tick;
  logic        rise;
  logic        fall;
  logic [3:0]  nb_clamped;
  logic [7:0]  rx_byte;
  logic [7:0]  nxt_byte;

  assign tick = (div_q == DIV_LAST);

  // Zero bytes still means one command byte; cap at buffer depth.
  always_comb begin
    nb_clamped = num_bytes;
    if (num_bytes == 4'd0) begin
      nb_clamped = 4'd1;
    end else if (num_bytes > MAXB) begin
      nb_clamped = MAXB;
    end
  end

  // Next-state, SPI bit engine and buffer updates.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    gap_d       = gap_q;
    bit_d       = bit_q;
    nbytes_d    = nbytes_q;
    cmd_d       = cmd_q;
    shift_d     = shift_q;
    ncs_d       = ncs_q;
    sck_d       = sck_q;
    mosi_d      = mosi_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    status_ok_d = status_ok_q;
    motors_en_d = motors_en_q;
    tx_buf_d    = tx_buf_q;
    rx_buf_d    = rx_buf_q;
    rise        = 1'b0;
    fall        = 1'b0;
    rx_byte     = {shift_q, spi.miso};
    nxt_byte    = cmd_q;

    if (tx_we && !busy_q && tx_addr != 4'd0 && tx_addr < MAXB) begin
      tx_buf_d[tx_addr] = tx_data;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          cmd_d    = {cmd_rw, cmd_code};
          nbytes_d = nb_clamped;
          ncs_d    = 1'b0;
          busy_d   = 1'b1;
          mosi_d   = cmd_rw;
          div_d    = '0;
          bit_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        div_d = tick ? '0 : div_q + 8'd1;
        if (tick) begin
          rise    = 1'b1;
          state_d = XFER;
        end
      end
      XFER: begin
        div_d = tick ? '0 : div_q + 8'd1;
        if (tick) begin
          fall = sck_q;
          rise = !sck_q;
        end
      end
      HOLD: begin
        div_d = tick ? '0 : div_q + 8'd1;
        if (tick) begin
          ncs_d   = 1'b1;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          gap_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        gap_d = gap_q + 16'd1;
        if (gap_q == GAP_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (rise) begin
      sck_d   = 1'b1;
      shift_d = rx_byte[6:0];
      bit_d   = bit_q + 7'd1;
      if (bit_q[2:0] == 3'd7) begin
        rx_buf_d[bit_q[6:3]] = rx_byte;
        if (bit_q[6:3] == 4'd0) begin
          status_ok_d = (rx_byte[7:6] == 2'b10);
          motors_en_d = rx_byte[5];
        end
      end
    end

    if (fall) begin
      sck_d = 1'b0;
      if (bit_q == {nbytes_q, 3'b000}) begin
        state_d = HOLD;
      end else begin
        if (bit_q[6:3] != 4'd0) begin
          nxt_byte = tx_buf_q[bit_q[6:3]];
        end
        mosi_d = nxt_byte[~bit_q[2:0]];
      end
    end
  end

  // State and buffer registers with synchronous reset.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      gap_q       <= '0;
      bit_q       <= '0;
      nbytes_q    <= 4'd1;
      cmd_q       <= '0;
      shift_q     <= '0;
      ncs_q       <= 1'b1;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      status_ok_q <= 1'b0;
      motors_en_q <= 1'b0;
      tx_buf_q    <= '{default: '0};
      rx_buf_q    <= '{default: '0};
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      gap_q       <= gap_d;
      bit_q       <= bit_d;
      nbytes_q    <= nbytes_d;
      cmd_q       <= cmd_d;
      shift_q     <= shift_d;
      ncs_q       <= ncs_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      status_ok_q <= status_ok_d;
      motors_en_q <= motors_en_d;
      tx_buf_q    <= tx_buf_d;
      rx_buf_q    <= rx_buf_d;
    end
  end

  // Response buffer read port; out-of-range indices read as zero.
  always_comb begin
    rx_data = 8'h00;
    if (rx_addr < MAXB) begin
      rx_data = rx_buf_q[rx_addr];
    end
  end

  assign spi.ncs   = ncs_q;
  assign spi.sck   = sck_q;
  assign spi.mosi  = mosi_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign status_ok = status_ok_q;
  assign motors_en = motors_en_q;

endmodule

// File: tb/tb_fpga_cmd_master.sv
// Directed plus randomized frames against an SPI slave model
// and a byte-level reference of the expected frame contents.
module tb_fpga_cmd_master;
  localparam int CLK_DIV = 4;
  localparam int GAPC    = 8;
  localparam int MAXB    = 15;

  logic       sysclk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cmd_rw = 1'b0;
  logic [6:0] cmd_code = '0;
  logic [3:0] num_bytes = '0;
  logic       tx_we = 1'b0;
  logic [3:0] tx_addr = '0;
  logic [7:0] tx_data = '0;
  logic [3:0] rx_addr = '0;
  logic [7:0] rx_data;
  logic       busy, done, status_ok, motors_en;

  fpga_cmd_master_if ifc();

  fpga_cmd_master #(
    .CLK_DIV(CLK_DIV),
    .GAP_CYCLES(GAPC),
    .MAX_BYTES(MAXB)
  ) dut (
    .sysclk(sysclk),
    .rst(rst),
    .start(start),
    .cmd_rw(cmd_rw),
    .cmd_code(cmd_code),
    .num_bytes(num_bytes),
    .tx_we(tx_we),
    .tx_addr(tx_addr),
    .tx_data(tx_data),
    .rx_addr(rx_addr),
    .rx_data(rx_data),
    .busy(busy),
    .done(done),
    .status_ok(status_ok),
    .motors_en(motors_en),
    .spi(ifc.master)
  );

  always #5 sysclk = ~sysclk;

  int tests_run = 0;
  int tests_failed = 0;

  // Slave model: response bits presented before each rise,
  // master bits captured on each rise.
  logic [7:0] resp [16];
  logic [7:0] mosi_rx [16];
  logic [7:0] rise_cnt = '0;

  assign ifc.miso = ifc.ncs ? 1'b0
                  : resp[rise_cnt[6:3]][3'd7 - rise_cnt[2:0]];

  always @(negedge ifc.ncs or posedge ifc.sck) begin
    if (ifc.sck) begin
      mosi_rx[rise_cnt[6:3]] = {mosi_rx[rise_cnt[6:3]][6:0], ifc.mosi};
      rise_cnt = rise_cnt + 8'd1;
    end else begin
      rise_cnt = '0;
      for (int i = 0; i < 16; i++) mosi_rx[i] = '0;
    end
  end

  // Bus monitors sampled mid-cycle.
  int   low_cyc, sckhi_cyc, gap_cyc, done_cnt, bad_cnt, ncs_falls;
  logic prev_ncs = 1'b1;

  always @(negedge sysclk) begin
    if (!ifc.ncs) low_cyc++;
    if (ifc.sck) sckhi_cyc++;
    if (busy && ifc.ncs) gap_cyc++;
    if (done) begin
      done_cnt++;
      if (!(ifc.ncs && !prev_ncs)) bad_cnt++;
    end
    if (ifc.sck && ifc.ncs) bad_cnt++;
    if (prev_ncs && !ifc.ncs) ncs_falls++;
    prev_ncs = ifc.ncs;
  end

  // Reference state: what the buffers and status should hold.
  logic [7:0] tx_m [16];
  logic [7:0] rx_m [16];
  logic       st_m, mo_m;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_mon();
    low_cyc = 0;
    sckhi_cyc = 0;
    gap_cyc = 0;
    done_cnt = 0;
    bad_cnt = 0;
    ncs_falls = 0;
  endtask

  task automatic clr_model();
    for (int i = 0; i < 16; i++) begin
      tx_m[i] = '0;
      rx_m[i] = '0;
    end
    st_m = 1'b0;
    mo_m = 1'b0;
  endtask

  task automatic write_tx(input int idx, input logic [7:0] d);
    @(negedge sysclk);
    tx_we = 1'b1;
    tx_addr = 4'(idx);
    tx_data = d;
    @(negedge sysclk);
    tx_we = 1'b0;
    if (idx >= 1 && idx < MAXB) tx_m[idx] = d;
  endtask

  task automatic start_frame(input int n, input logic rw,
                             input logic [6:0] code);
    @(negedge sysclk);
    start = 1'b1;
    cmd_rw = rw;
    cmd_code = code;
    num_bytes = 4'(n);
    @(posedge sysclk);
    #1;
    start = 1'b0;
    chk("start_ncs", 32'(ifc.ncs), 32'(0));
    chk("start_busy", 32'(busy), 32'(1));
    chk("start_mosi", 32'(ifc.mosi), 32'(rw));
  endtask

  task automatic wait_idle();
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge sysclk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'(1));
  endtask

  task automatic check_frame(input int nreq, input logic rw,
                             input logic [6:0] code);
    int n;
    logic [7:0] e;
    n = (nreq == 0) ? 1 : (nreq > MAXB ? MAXB : nreq);
    chk("ncs_low_cycles", 32'(low_cyc), 32'(CLK_DIV * (16 * n + 1)));
    chk("sck_rises", 32'(rise_cnt), 32'(8 * n));
    chk("sck_high_cycles", 32'(sckhi_cyc), 32'(CLK_DIV * 8 * n));
    chk("gap_cycles", 32'(gap_cyc), 32'(GAPC));
    chk("done_pulses", 32'(done_cnt), 32'(1));
    chk("bus_rules", 32'(bad_cnt), 32'(0));
    chk("frames", 32'(ncs_falls), 32'(1));
    for (int i = 0; i < n; i++) begin
      e = (i == 0) ? {rw, code} : tx_m[i];
      chk($sformatf("mosi_byte%0d", i), 32'(mosi_rx[i]), 32'(e));
      rx_m[i] = resp[i];
    end
    st_m = (resp[0][7:6] == 2'b10);
    mo_m = resp[0][5];
    for (int i = 0; i < MAXB; i++) begin
      rx_addr = 4'(i);
      #1;
      chk($sformatf("rx%0d", i), 32'(rx_data), 32'(rx_m[i]));
    end
    chk("status_ok", 32'(status_ok), 32'(st_m));
    chk("motors_en", 32'(motors_en), 32'(mo_m));
  endtask

  task automatic run(input int n, input logic rw, input logic [6:0] code);
    clr_mon();
    start_frame(n, rw, code);
    wait_idle();
    check_frame(n, rw, code);
  endtask

  initial begin
    logic ok;
    int   n;
    logic rw;
    logic [6:0] code;

    clr_model();
    for (int i = 0; i < 16; i++) resp[i] = '0;
    clr_mon();

    // Reset values.
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    rst = 1'b0;
    chk("rst_ncs", 32'(ifc.ncs), 32'(1));
    chk("rst_sck", 32'(ifc.sck), 32'(0));
    chk("rst_mosi", 32'(ifc.mosi), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_status", 32'(status_ok), 32'(0));
    chk("rst_motors", 32'(motors_en), 32'(0));
    for (int i = 0; i < MAXB; i++) begin
      rx_addr = 4'(i);
      #1;
      chk("rst_rx", 32'(rx_data), 32'(0));
    end

    // Single-byte read command, good status with motors.
    resp[0] = 8'hA3;
    run(1, 1'b1, 7'h00);

    // Eleven-byte write with payload echo.
    for (int i = 1; i <= 10; i++) write_tx(i, 8'(i));
    resp[0] = 8'h80;
    for (int i = 1; i <= 10; i++) resp[i] = 8'(8'h10 + i);
    run(11, 1'b0, 7'h00);

    // Byte-count clamping.
    resp[0] = 8'h9C;
    run(0, 1'b0, 7'h2B);
    for (int i = 0; i < 16; i++) resp[i] = 8'(8'hC0 + i);
    for (int i = 11; i < MAXB; i++) write_tx(i, 8'(8'h70 + i));
    run(15, 1'b1, 7'h55);

    // Bad status byte.
    resp[0] = 8'h45;
    run(1, 1'b1, 7'h01);

    // Requests while busy are ignored.
    write_tx(1, 8'h5A);
    write_tx(2, 8'hC3);
    resp[0] = 8'hA0;
    resp[1] = 8'h3C;
    clr_mon();
    start_frame(2, 1'b0, 7'h11);
    repeat (40) @(negedge sysclk);
    start = 1'b1;
    cmd_rw = 1'b1;
    cmd_code = 7'h7F;
    num_bytes = 4'd5;
    tx_we = 1'b1;
    tx_addr = 4'd1;
    tx_data = 8'hEE;
    @(negedge sysclk);
    start = 1'b0;
    tx_we = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sysclk);
      if (ifc.ncs) begin
        ok = 1'b1;
        break;
      end
    end
    chk("ncs_rise_timeout", 32'(ok), 32'(1));
    @(negedge sysclk);
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    wait_idle();
    check_frame(2, 1'b0, 7'h11);
    repeat (20) @(negedge sysclk);
    chk("no_second_frame", 32'(ncs_falls), 32'(1));
    chk("idle_ncs", 32'(ifc.ncs), 32'(1));
    chk("idle_busy", 32'(busy), 32'(0));

    // Reset during byte 2 aborts the frame.
    resp[2] = 8'h77;
    clr_mon();
    start_frame(4, 1'b1, 7'h22);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge sysclk);
      if (rise_cnt >= 8'd18) begin
        ok = 1'b1;
        break;
      end
    end
    chk("byte2_timeout", 32'(ok), 32'(1));
    rst = 1'b1;
    @(posedge sysclk);
    #1;
    chk("abort_ncs", 32'(ifc.ncs), 32'(1));
    chk("abort_sck", 32'(ifc.sck), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    @(negedge sysclk);
    rst = 1'b0;
    repeat (3) @(negedge sysclk);
    chk("abort_no_done", 32'(done_cnt), 32'(0));
    chk("abort_status", 32'(status_ok), 32'(0));
    clr_model();
    write_tx(1, 8'hB1);
    write_tx(2, 8'hB2);
    resp[0] = 8'hBF;
    resp[1] = 8'h01;
    resp[2] = 8'h02;
    run(3, 1'b0, 7'h33);

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      n = int'($urandom_range(0, 15));
      rw = 1'($urandom);
      code = 7'($urandom);
      for (int i = 1; i < MAXB; i++) begin
        if ($urandom_range(0, 1) == 1) write_tx(i, 8'($urandom));
      end
      for (int i = 0; i < 16; i++) resp[i] = 8'($urandom);
      run(n, rw, code);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fpga_cmd_master.md
FPGA_CMD_MASTER -- requirements
Module: fpga_cmd_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: sysclk cycles per SCK half-period; legal range 2..255.
REQ-002 SHALL have parameter GAP_CYCLES, default 8: minimum sysclk cycles ncs stays high between frames.
REQ-003 SHALL have parameter MAX_BYTES, default 15: frame buffer depth in bytes, including the command/status byte.
REQ-004 SHALL have port: sysclk  in  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port: rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port: start  in  1  frame request, sampled only in IDLE.
REQ-007 SHALL have port: cmd_rw  in  1  command MSB (1 = read type, 0 = write type).
REQ-008 SHALL have port: cmd_code  in  7  command code, sent as byte-0 bits 6:0.
REQ-009 SHALL have port: num_bytes  in  4  total frame bytes, command byte included.
REQ-010 SHALL have ports: tx_we / tx_addr / tx_data  in  1 / 4 / 8  payload write port for buffer indices 1..MAX_BYTES-1.
REQ-011 SHALL have ports: rx_addr in 4, rx_data out 8  combinational read of the response buffer; index 0 is the status byte.
REQ-012 SHALL have ports: busy out 1, done out 1  frame in progress; one-cycle completion pulse.
REQ-013 SHALL have ports: status_ok out 1, motors_en out 1  rx[0][7:6]==2'b10; rx[0][5].
REQ-014 SHALL have ports: ncs, sck, mosi out 1, miso in 1  SPI mode 0, MSB first.

Function
REQ-015 SHALL implement FSM states IDLE, SETUP, XFER, HOLD, GAP.
REQ-016 SHALL, in IDLE, accept start=1 at cycle T: latch cmd_rw, cmd_code and the clamped byte count; busy=1, ncs=0, mosi=byte0[7] from T+1.
REQ-017 SHALL clamp num_bytes: 0 -> 1; values above MAX_BYTES -> MAX_BYTES.
REQ-018 SHALL raise sck at T+1+CLK_DIV*(1+2k) and lower it at T+1+CLK_DIV*(2+2k), for k = 0..8N-1 (N = clamped byte count).
REQ-019 SHALL sample miso on each sck rise into a shift register.
REQ-020 SHALL update mosi on each sck fall, except the final fall, with the next bit; the byte after byte 0 comes from tx buffer index 1 onward.
REQ-021 SHALL, after every 8th rising edge, write the received byte to rx buffer index = byte number.
REQ-022 SHALL hold after the final sck fall (HOLD): ncs rises at T+1+CLK_DIV*(16N+1), done pulses that same cycle, mosi=0.
REQ-023 SHALL keep ncs high and busy=1 for GAP_CYCLES after ncs rises (GAP); busy falls when GAP ends and start is sampled again the next cycle.
REQ-024 SHALL ignore start when not in IDLE; SHALL ignore tx_we while busy=1.
REQ-025 SHALL update status_ok and motors_en only when byte 0 is stored; they hold their values between frames.
REQ-026 SHALL register every SPI output (no combinational path from inputs to ncs/sck/mosi); sck is low whenever ncs is high.

Reset
REQ-027 SHALL, on rst=1, drive the following from the next edge: IDLE, ncs=1, sck=0, mosi=0, busy=0, done=0, status_ok=0, motors_en=0.
REQ-028 SHALL clear the tx and rx buffers to 0x00 on reset.
REQ-029 SHALL, when rst is asserted mid-frame, abort the frame with no done pulse and no GAP enforcement.

Verification
REQ-030 Frame timing: N=1, cmd_rw=1, cmd_code=0x00, CLK_DIV=4, miso model returns 0xA3 -> ncs low for exactly 68 cycles; 8 sck pulses; done at ncs rise; rx[0]=0xA3; status_ok=1; motors_en=1.
REQ-031 Payload: N=11, cmd 0x00 write type, tx[1..10]=0x01..0x0A -> mosi byte stream is 0x00,0x01..0x0A; miso echo of 0x80,0x11..0x1A stored in rx[0..10]; status_ok=1, motors_en=0.
REQ-032 Clamping: num_bytes=0 gives 8 sck pulses; num_bytes=15 with MAX_BYTES=15 gives 120 pulses.
REQ-033 Ignored requests: start pulsed during XFER and during GAP -> no second frame; ncs stays high exactly GAP_CYCLES=8 before busy=0; tx_we while busy leaves tx unchanged.
REQ-034 Reset mid-frame: rst during byte 2 -> next cycle ncs=1, sck=0, busy=0, no done pulse; a subsequent start produces a correct full frame.
REQ-035 Bad status: miso byte 0 = 0x45 -> status_ok=0, motors_en=0; rx[0]=0x45.
